// File: rtl/i2c_txn_arbiter_pkg.sv
// Shared types and constants for the I2C transaction arbiter.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_NACK    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam int unsigned DEV_W  = 7;
  localparam int unsigned BYTE_W = 8;

endpackage

// File: rtl/i2c_txn_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr, circularly.
module rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx
);

  logic [PW-1:0] w_k;
  logic          w_found;

  always_comb begin
    onehot  = '0;
    idx     = '0;
    w_found = 1'b0;
    w_k     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_k = PW'((32'(ptr) + i) % N);
      if (!w_found && req[w_k]) begin
        w_found     = 1'b1;
        onehot[w_k] = 1'b1;
        idx         = w_k;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin owner of a shared byte-oriented I2C master; one register transaction per grant,
// supervised by a WAIT-state timeout, with a one-cycle done/irq completion pulse.
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int TO_W           = 19
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [DEV_W*NUM_REQ-1:0]    req_dev,
  input  logic [NUM_REQ-1:0]          req_rnw,
  input  logic [BYTE_W*NUM_REQ-1:0]   req_reg,
  input  logic [BYTE_W*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          done,
  output logic [BYTE_W-1:0]           rdata,
  output logic [1:0]                  status,
  output logic                        irq,
  output logic                        m_start,
  input  logic                        m_ready,
  output logic [DEV_W-1:0]            m_dev,
  output logic                        m_rnw,
  output logic [BYTE_W-1:0]           m_reg,
  output logic [BYTE_W-1:0]           m_wdata,
  input  logic                        m_done,
  input  logic [BYTE_W-1:0]           m_rdata,
  input  logic                        m_nack,
  output logic                        m_abort
);

  localparam int unsigned PW = $clog2(NUM_REQ);

  state_t              r_state, w_state_n;
  logic [NUM_REQ-1:0]  r_grant;
  logic [PW-1:0]       r_ptr, r_own;
  logic [TO_W-1:0]     r_cnt;
  logic [BYTE_W-1:0]   r_rdata;
  logic [1:0]          r_status;
  logic                r_abort;
  logic [DEV_W-1:0]    r_dev;
  logic                r_rnw;
  logic [BYTE_W-1:0]   r_reg, r_wdata;

  logic [NUM_REQ-1:0]  w_onehot;
  logic [PW-1:0]       w_idx;
  logic [DEV_W-1:0]    w_dev;
  logic                w_rnw;
  logic [BYTE_W-1:0]   w_reg, w_wdata;
  logic                w_latch, w_cap, w_to;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .onehot (w_onehot),
    .idx    (w_idx)
  );

  always_comb begin
    w_dev   = '0;
    w_rnw   = 1'b0;
    w_reg   = '0;
    w_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_idx == PW'(i)) begin
        w_dev   = req_dev[i*DEV_W +: DEV_W];
        w_rnw   = req_rnw[i];
        w_reg   = req_reg[i*BYTE_W +: BYTE_W];
        w_wdata = req_wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_latch   = 1'b0;
    w_cap     = 1'b0;
    w_to      = 1'b0;
    unique case (r_state)
      S_IDLE:  if (|req) begin
                 w_latch   = 1'b1;
                 w_state_n = S_ISSUE;
               end
      S_ISSUE: if (m_ready) w_state_n = S_WAIT;
      // m_done takes priority over a timeout falling on the same cycle
      S_WAIT:  if (m_done) begin
                 w_cap     = 1'b1;
                 w_state_n = S_RESP;
               end else if (r_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                 w_to      = 1'b1;
                 w_state_n = S_RESP;
               end
      S_RESP:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant  <= '0;
      r_ptr    <= '0;
      r_own    <= '0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_status <= ST_OK;
      r_abort  <= 1'b0;
      r_dev    <= '0;
      r_rnw    <= 1'b0;
      r_reg    <= '0;
      r_wdata  <= '0;
    end else begin
      r_abort <= w_to;
      if (w_latch) begin
        r_grant <= w_onehot;
        r_own   <= w_idx;
        r_dev   <= w_dev;
        r_rnw   <= w_rnw;
        r_reg   <= w_reg;
        r_wdata <= w_wdata;
      end
      if (r_state == S_ISSUE && m_ready) r_cnt <= '0;
      else if (r_state == S_WAIT)        r_cnt <= r_cnt + 1'b1;
      if (w_cap) begin
        r_rdata  <= r_rnw ? m_rdata : '0;
        r_status <= m_nack ? ST_NACK : ST_OK;
      end
      if (w_to) begin
        r_rdata  <= '0;
        r_status <= ST_TIMEOUT;
      end
      if (r_state == S_RESP) begin
        r_grant <= '0;
        r_ptr   <= (r_own == PW'(NUM_REQ - 1)) ? '0 : r_own + 1'b1;
      end
    end
  end

  assign grant   = r_grant;
  assign irq     = (r_state == S_RESP);
  assign done    = irq ? r_grant : '0;
  assign rdata   = r_rdata;
  assign status  = r_status;
  assign m_start = (r_state == S_ISSUE);
  assign m_abort = r_abort;
  assign m_dev   = r_dev;
  assign m_rnw   = r_rnw;
  assign m_reg   = r_reg;
  assign m_wdata = r_wdata;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter: vector table of single transactions plus
// timeout, coincident done/timeout, reset-mid-WAIT and contention sequences.
module tb_i2c_txn_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [13:0] req_dev;
  logic [1:0]  req_rnw;
  logic [15:0] req_reg;
  logic [15:0] req_wdata;
  logic [1:0]  grant, done, status;
  logic [7:0]  rdata;
  logic        irq, m_start, m_ready, m_rnw, m_done, m_nack, m_abort;
  logic [6:0]  m_dev;
  logic [7:0]  m_reg, m_wdata, m_rdata;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  i2c_txn_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(100), .TO_W(7)) dut (
    .clk(clk), .reset(reset), .req(req), .req_dev(req_dev), .req_rnw(req_rnw),
    .req_reg(req_reg), .req_wdata(req_wdata), .grant(grant), .done(done),
    .rdata(rdata), .status(status), .irq(irq), .m_start(m_start),
    .m_ready(m_ready), .m_dev(m_dev), .m_rnw(m_rnw), .m_reg(m_reg),
    .m_wdata(m_wdata), .m_done(m_done), .m_rdata(m_rdata), .m_nack(m_nack),
    .m_abort(m_abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [13:0] dev;
    logic [1:0]  rnw;
    logic [15:0] rg;
    logic [15:0] wd;
    int          rdly;
    int          lat;
    logic [7:0]  rd;
    logic        nk;
    logic        drop;
    logic [1:0]  eg;
    logic [7:0]  erd;
    logic [1:0]  est;
    logic [6:0]  edev;
    logic [7:0]  ereg;
    logic [7:0]  ewd;
    logic        ernw;
  } vec_t;

  vec_t tbl[6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      checks++;
      if (!$onehot0(grant)) begin
        errors++;
        $display("FAIL grant_onehot actual=%b required=onehot0", grant);
      end
      checks++;
      if ((done & ~grant) != 2'b00 || irq !== (|done)) begin
        errors++;
        $display("FAIL done_irq actual=done %b irq %b grant %b required=done within grant, irq=|done",
                 done, irq, grant);
      end
    end
  end

  // Drives one transaction from the IDLE cycle through the cycle after RESP.
  task automatic do_txn(input string tag, input logic [1:0] eg, input int rdly, input int lat,
                        input logic [7:0] rd, input logic nk, input logic drop,
                        input logic [7:0] erd, input logic [1:0] est, input logic [6:0] edev,
                        input logic [7:0] ereg, input logic [7:0] ewd, input logic ernw);
    m_ready = (rdly == 0);
    tick;
    chk({tag, "_grant"}, grant, eg);
    chk({tag, "_mstart"}, m_start, 1);
    chk({tag, "_mdev"}, m_dev, edev);
    chk({tag, "_mreg"}, m_reg, ereg);
    chk({tag, "_mwdata"}, m_wdata, ewd);
    chk({tag, "_mrnw"}, m_rnw, ernw);
    if (rdly > 0) begin
      repeat (rdly) tick;
      chk({tag, "_mstart_hold"}, m_start, 1);
      m_ready = 1'b1;
    end
    tick;
    m_ready = 1'b0;
    chk({tag, "_mstart_off"}, m_start, 0);
    if (drop) begin
      req     = 2'b00;
      req_dev = ~req_dev;
      req_reg = ~req_reg;
    end
    repeat (lat - 1) tick;
    chk({tag, "_mreg_stable"}, m_reg, ereg);
    chk({tag, "_done_early"}, done, 0);
    m_done = 1'b1; m_rdata = rd; m_nack = nk;
    tick;
    m_done = 1'b0; m_rdata = 8'h99; m_nack = 1'b0;
    chk({tag, "_done"}, done, eg);
    chk({tag, "_irq"}, irq, 1);
    chk({tag, "_status"}, status, est);
    chk({tag, "_rdata"}, rdata, erd);
    chk({tag, "_abort"}, m_abort, 0);
    tick;
    chk({tag, "_done_clr"}, done, 0);
    chk({tag, "_grant_clr"}, grant, 0);
    chk({tag, "_rdata_hold"}, rdata, erd);
    chk({tag, "_status_hold"}, status, est);
  endtask

  initial begin
    tbl[0] = '{2'b01, {7'h00, 7'h53}, 2'b00, {8'h00, 8'h2D}, {8'h00, 8'h08}, 0, 20, 8'h11, 1'b0, 1'b0,
               2'b01, 8'h00, 2'b00, 7'h53, 8'h2D, 8'h08, 1'b0};
    tbl[1] = '{2'b10, {7'h1D, 7'h53}, 2'b10, {8'h32, 8'h2D}, {8'h00, 8'h08}, 0, 5, 8'hA5, 1'b0, 1'b0,
               2'b10, 8'hA5, 2'b00, 7'h1D, 8'h32, 8'h00, 1'b1};
    tbl[2] = '{2'b01, {7'h1D, 7'h50}, 2'b00, {8'h32, 8'h10}, {8'h00, 8'h77}, 4, 3, 8'h00, 1'b1, 1'b0,
               2'b01, 8'h00, 2'b01, 7'h50, 8'h10, 8'h77, 1'b0};
    tbl[3] = '{2'b11, {7'h68, 7'h50}, 2'b10, {8'h75, 8'h10}, {8'h44, 8'h77}, 1, 7, 8'h3C, 1'b0, 1'b1,
               2'b10, 8'h3C, 2'b00, 7'h68, 8'h75, 8'h44, 1'b1};
    tbl[4] = '{2'b01, {7'h68, 7'h2A}, 2'b00, {8'h75, 8'h0F}, {8'h44, 8'hF0}, 0, 1, 8'hEE, 1'b0, 1'b0,
               2'b01, 8'h00, 2'b00, 7'h2A, 8'h0F, 8'hF0, 1'b0};
    tbl[5] = '{2'b11, {7'h7F, 7'h2A}, 2'b11, {8'hFF, 8'h0F}, {8'h00, 8'hF0}, 2, 2, 8'hC3, 1'b0, 1'b0,
               2'b10, 8'hC3, 2'b00, 7'h7F, 8'hFF, 8'h00, 1'b1};

    reset = 1'b1; req = '0; req_dev = '0; req_rnw = '0; req_reg = '0; req_wdata = '0;
    m_ready = 1'b0; m_done = 1'b0; m_rdata = '0; m_nack = 1'b0;
    tick; tick;
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_status", status, 0);
    chk("rst_irq", irq, 0);
    chk("rst_mstart", m_start, 0);
    chk("rst_abort", m_abort, 0);
    chk("rst_mcmd", {m_dev, m_rnw, m_reg, m_wdata}, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 6; i++) begin
      req = tbl[i].req; req_dev = tbl[i].dev; req_rnw = tbl[i].rnw;
      req_reg = tbl[i].rg; req_wdata = tbl[i].wd;
      do_txn($sformatf("vec%0d", i), tbl[i].eg, tbl[i].rdly, tbl[i].lat, tbl[i].rd, tbl[i].nk,
             tbl[i].drop, tbl[i].erd, tbl[i].est, tbl[i].edev, tbl[i].ereg, tbl[i].ewd, tbl[i].ernw);
    end

    // Timeout: abort arrives 100 cycles after the WAIT entry edge and clears rdata.
    req = 2'b10; req_dev = {7'h22, 7'h00}; req_rnw = 2'b10; req_reg = {8'h01, 8'h00};
    m_ready = 1'b1;
    tick;
    chk("to_grant", grant, 2'b10);
    tick;
    m_ready = 1'b0; req = 2'b00;
    repeat (99) tick;
    chk("to_abort_early", m_abort, 0);
    chk("to_done_early", done, 0);
    tick;
    chk("to_abort", m_abort, 1);
    chk("to_done", done, 2'b10);
    chk("to_status", status, 2'b10);
    chk("to_rdata", rdata, 0);
    tick;
    chk("to_abort_clr", m_abort, 0);
    chk("to_grant_clr", grant, 0);

    // m_done on the timeout cycle wins.
    req = 2'b01; req_dev = {7'h22, 7'h3A}; req_rnw = 2'b01; req_reg = {8'h01, 8'h05};
    m_ready = 1'b1;
    tick;
    chk("tie_grant", grant, 2'b01);
    tick;
    m_ready = 1'b0; req = 2'b00;
    repeat (99) tick;
    m_done = 1'b1; m_rdata = 8'h5A;
    tick;
    m_done = 1'b0;
    chk("tie_abort", m_abort, 0);
    chk("tie_status", status, 2'b00);
    chk("tie_rdata", rdata, 8'h5A);
    chk("tie_done", done, 2'b01);
    tick;
    chk("tie_abort_after", m_abort, 0);

    // Reset mid-WAIT cancels silently; late m_done is ignored; pointer returns to 0.
    req = 2'b10; req_dev = {7'h0C, 7'h3A}; req_rnw = 2'b00;
    m_ready = 1'b1;
    tick;
    chk("rw_grant", grant, 2'b10);
    tick;
    m_ready = 1'b0; req = 2'b00;
    repeat (5) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rw_grant_clr", grant, 0);
    chk("rw_done", done, 0);
    chk("rw_mstart", m_start, 0);
    chk("rw_rdata", rdata, 0);
    m_done = 1'b1; m_rdata = 8'hFF;
    tick;
    m_done = 1'b0;
    chk("rw_late_done", done, 0);
    chk("rw_late_irq", irq, 0);
    chk("rw_late_rdata", rdata, 0);

    // Contention with both held: strict alternation 0,1,0,1 with one IDLE cycle between.
    req = 2'b11; req_dev = {7'h11, 7'h22}; req_rnw = 2'b01;
    req_reg = {8'hB1, 8'hA0}; req_wdata = {8'h1B, 8'h0A};
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0)
        do_txn($sformatf("ct%0d", k), 2'b01, 0, 2, 8'h90 + 8'(k), 1'b0, 1'b0,
               8'h90 + 8'(k), 2'b00, 7'h22, 8'hA0, 8'h0A, 1'b1);
      else
        do_txn($sformatf("ct%0d", k), 2'b10, 0, 2, 8'h90 + 8'(k), 1'b0, 1'b0,
               8'h00, 2'b00, 7'h11, 8'hB1, 8'h1B, 1'b0);
    end
    req = 2'b00;
    tick;
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
